// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI byte sequencer.
package spi_pkg;
  localparam int SPI_BYTE_W = 8;
  localparam logic [SPI_BYTE_W-1:0] SPI_FILL_BYTE = 8'hFF;
  typedef enum logic [2:0] {IDLE, CS_SETUP, ISSUE, WAIT_RX, CS_HOLD} state_t;
endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: show-ahead synchronous FIFO with occupancy count.
module spi_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_wr_en,
  input  logic [W-1:0]             i_wr_data,
  input  logic                     i_rd_en,
  output logic [W-1:0]             o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;
  // A write while full is still accepted when a pop frees the slot this cycle
  assign w_pop     = i_rd_en && !o_empty;
  assign w_push    = i_wr_en && (!o_full || w_pop);
  assign o_full    = r_count == (AW+1)'(DEPTH);
  assign o_empty   = r_count == '0;
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/spi_byte_sequencer.sv
// spi_byte_sequencer: multi-byte SPI transaction engine with TX/RX FIFOs and chip select.
// Define SPI_SEQ_TX_FILL_EN to send SPI_FILL_BYTE instead of stalling when the TX FIFO is empty.
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_start,
  input  logic [LEN_W-1:0]              i_len,
  output logic                          o_busy,
  output logic                          o_done,
  input  logic                          i_wr_en,
  input  logic [SPI_BYTE_W-1:0]         i_wr_data,
  output logic                          o_tx_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_tx_count,
  input  logic                          i_rd_en,
  output logic [SPI_BYTE_W-1:0]         o_rd_data,
  output logic                          o_rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_rx_count,
  output logic [SPI_BYTE_W-1:0]         o_ctl_tx_byte,
  output logic                          o_ctl_tx_dv,
  input  logic                          i_ctl_tx_ready,
  input  logic                          i_ctl_rx_dv,
  input  logic [SPI_BYTE_W-1:0]         i_ctl_rx_byte,
  output logic                          o_spi_cs_n
);
  state_t                r_state, w_next;
  logic [LEN_W-1:0]      r_remaining;
  logic                  r_cs_n, r_done, r_tx_dv;
  logic [SPI_BYTE_W-1:0] r_tx_byte, w_tx_byte_nxt, w_tx_head;
  logic                  w_tx_empty, w_rx_full, w_tx_avail, w_issue_ok;
  logic                  w_fire, w_tx_pop, w_rx_push, w_cs_n_nxt, w_done_nxt;

  spi_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(SPI_BYTE_W)) u_tx_fifo (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .i_rd_en(w_tx_pop), .o_rd_data(w_tx_head),
    .o_full(o_tx_full), .o_empty(w_tx_empty), .o_count(o_tx_count)
  );

  spi_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(SPI_BYTE_W)) u_rx_fifo (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_wr_en(w_rx_push), .i_wr_data(i_ctl_rx_byte),
    .i_rd_en(i_rd_en), .o_rd_data(o_rd_data),
    .o_full(w_rx_full), .o_empty(o_rx_empty), .o_count(o_rx_count)
  );

`ifdef SPI_SEQ_TX_FILL_EN
  assign w_tx_avail = 1'b1;
`else
  assign w_tx_avail = !w_tx_empty;
`endif
  // RX slot is reserved before issue, so the controller's reply can always be stored
  assign w_issue_ok = i_ctl_tx_ready && w_tx_avail && !w_rx_full;

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_cs_n      <= 1'b1;
      r_done      <= 1'b0;
      r_tx_dv     <= 1'b0;
      r_tx_byte   <= '0;
    end else begin
      r_state     <= w_next;
      r_remaining <= (r_state == IDLE && i_start) ? i_len :
                     w_rx_push ? r_remaining - LEN_W'(1) : r_remaining;
      r_cs_n      <= w_cs_n_nxt;
      r_done      <= w_done_nxt;
      r_tx_dv     <= w_fire;
      r_tx_byte   <= w_tx_byte_nxt;
    end

  // CS_SETUP already holds CS low, so the first byte may be issued as it ends
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:            if (i_start && i_len != '0) w_next = CS_SETUP;
      CS_SETUP, ISSUE: w_next = w_issue_ok ? WAIT_RX : ISSUE;
      WAIT_RX:         if (i_ctl_rx_dv) w_next = (r_remaining == LEN_W'(1)) ? CS_HOLD : ISSUE;
      CS_HOLD:         w_next = IDLE;
      default:         w_next = IDLE;
    endcase
  end

  always_comb begin
    w_fire        = (r_state == CS_SETUP || r_state == ISSUE) && w_issue_ok;
    w_tx_pop      = w_fire && !w_tx_empty;
    w_rx_push     = (r_state == WAIT_RX) && i_ctl_rx_dv;
    w_cs_n_nxt    = (w_next == IDLE);
    w_done_nxt    = (r_state == CS_HOLD) || (r_state == IDLE && i_start && i_len == '0);
    w_tx_byte_nxt = w_fire ? (w_tx_empty ? SPI_FILL_BYTE : w_tx_head) : r_tx_byte;
  end

  assign o_busy        = r_state != IDLE;
  assign o_done        = r_done;
  assign o_ctl_tx_dv   = r_tx_dv;
  assign o_ctl_tx_byte = r_tx_byte;
  assign o_spi_cs_n    = r_cs_n;
endmodule

// File: tb/tb_spi_byte_sequencer.sv
// tb_spi_byte_sequencer: randomized loopback bench with a queue-based transaction model.
module tb_spi_byte_sequencer;
  localparam int DEPTH = 8;
  logic i_clk = 0, i_reset_n = 0, i_start = 0, i_wr_en = 0, i_rd_en = 0;
  logic i_ctl_tx_ready = 1, i_ctl_rx_dv = 0;
  logic [7:0] i_len = 0, i_wr_data = 0, i_ctl_rx_byte = 0;
  logic o_busy, o_done, o_tx_full, o_rx_empty, o_ctl_tx_dv, o_spi_cs_n;
  logic [7:0] o_rd_data, o_ctl_tx_byte;
  logic [3:0] o_tx_count, o_rx_count;

  int checks = 0, errors = 0, cyc = 0, lat_lo = 0, lat_hi = 2, cs_low_cnt = 0, start_cyc = 0;
  logic [7:0] sent_q[$], tx_exp[$], rx_exp[$], exp_sent[$];
  int sent_cyc[$], rx_cyc[$], done_cyc[$];
  logic done_busy = 0, done_cs = 0;
  bit ctl_busy = 0;
  int ctl_cnt = 0;
  logic [7:0] ctl_byte = 0;

  spi_byte_sequencer #(.FIFO_DEPTH(DEPTH), .LEN_W(8)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .o_tx_full(o_tx_full), .o_tx_count(o_tx_count), .i_rd_en(i_rd_en),
    .o_rd_data(o_rd_data), .o_rx_empty(o_rx_empty), .o_rx_count(o_rx_count),
    .o_ctl_tx_byte(o_ctl_tx_byte), .o_ctl_tx_dv(o_ctl_tx_dv),
    .i_ctl_tx_ready(i_ctl_tx_ready), .i_ctl_rx_dv(i_ctl_rx_dv),
    .i_ctl_rx_byte(i_ctl_rx_byte), .o_spi_cs_n(o_spi_cs_n)
  );

  always #5 i_clk = ~i_clk;

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  initial forever begin
    @(negedge i_clk);
    if (o_ctl_tx_dv) begin
      sent_q.push_back(o_ctl_tx_byte);
      sent_cyc.push_back(cyc);
    end
    if (o_done) begin
      done_cyc.push_back(cyc);
      done_busy = o_busy;
      done_cs = o_spi_cs_n;
    end
    if (!o_spi_cs_n) cs_low_cnt++;
  end

  // Loopback controller: echoes each issued byte after a random latency, tx_ready returns with rx_dv
  initial forever begin
    @(posedge i_clk);
    #1;
    i_ctl_rx_dv = 0;
    i_ctl_rx_byte = 8'($urandom);
    if (!i_reset_n) begin
      ctl_busy = 0;
      i_ctl_tx_ready = 1;
    end else if (ctl_busy) begin
      if (ctl_cnt == 0) begin
        i_ctl_rx_dv = 1;
        i_ctl_rx_byte = ctl_byte;
        i_ctl_tx_ready = 1;
        ctl_busy = 0;
        rx_cyc.push_back(cyc);
      end else ctl_cnt--;
    end else if (o_ctl_tx_dv) begin
      ctl_busy = 1;
      ctl_byte = o_ctl_tx_byte;
      ctl_cnt = int'($urandom_range(lat_hi, lat_lo));
      i_ctl_tx_ready = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr();
    sent_q.delete(); sent_cyc.delete(); rx_cyc.delete(); done_cyc.delete();
    cs_low_cnt = 0;
  endtask

  task automatic wr(input logic [7:0] b, input bit keep);
    tick();
    i_wr_en = 1;
    i_wr_data = b;
    if (keep) tx_exp.push_back(b);
    tick();
    i_wr_en = 0;
  endtask

  task automatic start(input int len);
    tick();
    i_start = 1;
    i_len = 8'(len);
    start_cyc = cyc;
    tick();
    i_start = 0;
  endtask

  task automatic pop(output logic [7:0] b);
    tick();
    b = o_rd_data;
    i_rd_en = 1;
    tick();
    i_rd_en = 0;
  endtask

  // Model: each issued byte is the next host byte (fill byte if none), echoed into RX
  task automatic model_xfer(input int len);
    exp_sent.delete();
    for (int i = 0; i < len; i++) begin
      exp_sent.push_back(tx_exp.size() != 0 ? tx_exp.pop_front() : 8'hFF);
      rx_exp.push_back(exp_sent[i]);
    end
  endtask

  task automatic wait_done(input int bound);
    int t = 0;
    while (done_cyc.size() == 0 && t < bound) begin tick(); t++; end
    checks++;
    if (done_cyc.size() == 0) begin errors++; $display("FAIL done_timeout: no o_done within %0d cycles", bound); end
  endtask

  task automatic wait_sent(input int n, input int bound);
    int t = 0;
    while (sent_q.size() < n && t < bound) begin tick(); t++; end
    checks++;
    if (sent_q.size() < n) begin errors++; $display("FAIL sent_timeout: got %0d bytes need %0d", sent_q.size(), n); end
  endtask

  task automatic test_reset();
    #22;
    checks += 10;
    if (o_spi_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n got %b exp 1", o_spi_cs_n); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", o_busy); end
    if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", o_done); end
    if (o_ctl_tx_dv !== 1'b0) begin errors++; $display("FAIL rst_tx_dv got %b exp 0", o_ctl_tx_dv); end
    if (o_ctl_tx_byte !== 8'h00) begin errors++; $display("FAIL rst_tx_byte got %h exp 00", o_ctl_tx_byte); end
    if (o_tx_count !== 4'd0) begin errors++; $display("FAIL rst_tx_count got %0d exp 0", o_tx_count); end
    if (o_rx_count !== 4'd0) begin errors++; $display("FAIL rst_rx_count got %0d exp 0", o_rx_count); end
    if (o_rx_empty !== 1'b1) begin errors++; $display("FAIL rst_rx_empty got %b exp 1", o_rx_empty); end
    if (o_tx_full !== 1'b0) begin errors++; $display("FAIL rst_tx_full got %b exp 0", o_tx_full); end
    if (o_rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h exp 00", o_rd_data); end
    @(negedge i_clk);
    i_reset_n = 1;
  endtask

  task automatic test_basic();
    logic [7:0] b, e;
    clr();
    wr(8'hA5, 1); wr(8'h3C, 1); wr(8'h0F, 1);
    model_xfer(3);
    start(3);
    checks += 2;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_k1 got %b exp 1", o_busy); end
    if (o_spi_cs_n !== 1'b0) begin errors++; $display("FAIL basic_cs_k1 got %b exp 0", o_spi_cs_n); end
    wait_done(200);
    tick();
    checks++;
    if (sent_q.size() != 3) begin errors++; $display("FAIL basic_count got %0d exp 3", sent_q.size()); end
    foreach (exp_sent[i]) if (i < sent_q.size()) begin
      checks++;
      if (sent_q[i] !== exp_sent[i]) begin errors++; $display("FAIL basic_tx[%0d] got %h exp %h", i, sent_q[i], exp_sent[i]); end
    end
    if (sent_q.size() == 3 && rx_cyc.size() == 3 && done_cyc.size() == 1) begin
      checks += 6;
      if (sent_cyc[0] != start_cyc + 2) begin errors++; $display("FAIL basic_first_dv got %0d exp %0d", sent_cyc[0], start_cyc + 2); end
      for (int i = 1; i < 3; i++)
        if (sent_cyc[i] != rx_cyc[i-1] + 2) begin errors++; $display("FAIL basic_gap[%0d] got %0d exp %0d", i, sent_cyc[i], rx_cyc[i-1] + 2); end
      if (done_cyc[0] != rx_cyc[2] + 2) begin errors++; $display("FAIL basic_done_cyc got %0d exp %0d", done_cyc[0], rx_cyc[2] + 2); end
      if (cs_low_cnt != done_cyc[0] - start_cyc - 1) begin errors++; $display("FAIL basic_cs_low got %0d exp %0d", cs_low_cnt, done_cyc[0] - start_cyc - 1); end
      if (done_busy !== 1'b0 || done_cs !== 1'b1) begin errors++; $display("FAIL basic_done_state busy %b cs_n %b exp 0 1", done_busy, done_cs); end
    end
    checks++;
    if (o_rx_count !== 4'd3) begin errors++; $display("FAIL basic_rx_count got %0d exp 3", o_rx_count); end
    while (rx_exp.size() > 0) begin
      pop(b); e = rx_exp.pop_front(); checks++;
      if (b !== e) begin errors++; $display("FAIL basic_rx got %h exp %h", b, e); end
    end
    checks++;
    if (o_rx_empty !== 1'b1) begin errors++; $display("FAIL basic_rx_empty got %b exp 1", o_rx_empty); end
  endtask

  task automatic test_random();
    logic [7:0] b, e;
    for (int n = 0; n < 6; n++) begin
      int len = int'($urandom_range(7, 1));
      clr();
      lat_lo = 0; lat_hi = int'($urandom_range(3, 0));
      for (int i = 0; i < len; i++) wr(8'($urandom), 1);
      model_xfer(len);
      start(len);
      wait_done(300);
      tick();
      checks += 2;
      if (sent_q.size() != len) begin errors++; $display("FAIL rand_count got %0d exp %0d", sent_q.size(), len); end
      if (done_cyc.size() != 1) begin errors++; $display("FAIL rand_done_pulses got %0d exp 1", done_cyc.size()); end
      foreach (exp_sent[i]) if (i < sent_q.size()) begin
        checks++;
        if (sent_q[i] !== exp_sent[i]) begin errors++; $display("FAIL rand_tx[%0d] got %h exp %h", i, sent_q[i], exp_sent[i]); end
      end
      while (rx_exp.size() > 0) begin
        pop(b); e = rx_exp.pop_front(); checks++;
        if (b !== e) begin errors++; $display("FAIL rand_rx got %h exp %h", b, e); end
      end
    end
    lat_hi = 2;
  endtask

  task automatic test_zero_len();
    logic [7:0] h;
    clr();
    h = o_rd_data;
    tick();
    i_rd_en = 1;
    tick();
    i_rd_en = 0;
    checks++;
    if (o_rd_data !== h || o_rx_count !== 4'd0) begin errors++; $display("FAIL empty_pop rd %h cnt %0d exp %h 0", o_rd_data, o_rx_count, h); end
    start(0);
    repeat (5) tick();
    checks += 4;
    if (done_cyc.size() != 1) begin errors++; $display("FAIL zero_done_pulses got %0d exp 1", done_cyc.size()); end
    else if (done_cyc[0] != start_cyc + 1) begin errors++; $display("FAIL zero_done_cyc got %0d exp %0d", done_cyc[0], start_cyc + 1); end
    if (cs_low_cnt != 0) begin errors++; $display("FAIL zero_cs_low got %0d exp 0", cs_low_cnt); end
    if (sent_q.size() != 0) begin errors++; $display("FAIL zero_tx_dv got %0d exp 0", sent_q.size()); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", o_busy); end
  endtask

  task automatic test_backpressure();
    logic [7:0] b, e;
    int t = 0;
    clr();
    lat_lo = 0; lat_hi = 1;
    for (int i = 0; i < 8; i++) wr(8'($urandom), 1);
    start(10);
    while (o_tx_count > 4'd6 && t < 100) begin tick(); t++; end
    wr(8'($urandom), 1); wr(8'($urandom), 1);
    model_xfer(10);
    repeat (80) tick();
    checks += 5;
    if (sent_q.size() != 8) begin errors++; $display("FAIL bp_issued got %0d exp 8", sent_q.size()); end
    if (o_rx_count !== 4'd8) begin errors++; $display("FAIL bp_rx_count got %0d exp 8", o_rx_count); end
    if (o_spi_cs_n !== 1'b0) begin errors++; $display("FAIL bp_cs got %b exp 0", o_spi_cs_n); end
    if (o_busy !== 1'b1) begin errors++; $display("FAIL bp_busy got %b exp 1", o_busy); end
    if (done_cyc.size() != 0) begin errors++; $display("FAIL bp_early_done got %0d exp 0", done_cyc.size()); end
    for (int i = 0; i < 2; i++) begin
      pop(b); e = rx_exp.pop_front(); checks++;
      if (b !== e) begin errors++; $display("FAIL bp_pop got %h exp %h", b, e); end
    end
    wait_done(200);
    tick();
    checks++;
    if (sent_q.size() != 10) begin errors++; $display("FAIL bp_total got %0d exp 10", sent_q.size()); end
    foreach (exp_sent[i]) if (i < sent_q.size()) begin
      checks++;
      if (sent_q[i] !== exp_sent[i]) begin errors++; $display("FAIL bp_tx[%0d] got %h exp %h", i, sent_q[i], exp_sent[i]); end
    end
    while (rx_exp.size() > 0) begin
      pop(b); e = rx_exp.pop_front(); checks++;
      if (b !== e) begin errors++; $display("FAIL bp_rx got %h exp %h", b, e); end
    end
    lat_hi = 2;
  endtask

  task automatic test_underflow();
    logic [7:0] b, e;
    clr();
    lat_lo = 0; lat_hi = 0;
    start(2);
`ifdef SPI_SEQ_TX_FILL_EN
    model_xfer(2);
`else
    repeat (20) tick();
    checks += 3;
    if (sent_q.size() != 0) begin errors++; $display("FAIL uf_stall1 got %0d exp 0", sent_q.size()); end
    if (o_spi_cs_n !== 1'b0) begin errors++; $display("FAIL uf_cs got %b exp 0", o_spi_cs_n); end
    if (o_busy !== 1'b1) begin errors++; $display("FAIL uf_busy got %b exp 1", o_busy); end
    wr(8'h55, 1);
    wait_sent(1, 50);
    repeat (20) tick();
    checks += 2;
    if (sent_q.size() != 1) begin errors++; $display("FAIL uf_stall2 got %0d exp 1", sent_q.size()); end
    if (done_cyc.size() != 0) begin errors++; $display("FAIL uf_early_done got %0d exp 0", done_cyc.size()); end
    wr(8'($urandom), 1);
    model_xfer(2);
`endif
    wait_done(100);
    tick();
    checks++;
    if (sent_q.size() != 2) begin errors++; $display("FAIL uf_count got %0d exp 2", sent_q.size()); end
    foreach (exp_sent[i]) if (i < sent_q.size()) begin
      checks++;
      if (sent_q[i] !== exp_sent[i]) begin errors++; $display("FAIL uf_tx[%0d] got %h exp %h", i, sent_q[i], exp_sent[i]); end
    end
    while (rx_exp.size() > 0) begin
      pop(b); e = rx_exp.pop_front(); checks++;
      if (b !== e) begin errors++; $display("FAIL uf_rx got %h exp %h", b, e); end
    end
    lat_hi = 2;
  endtask

  task automatic test_overflow();
    logic [7:0] b, e, x;
    int t = 0;
    clr();
    for (int i = 0; i < 9; i++) wr(8'($urandom), i < DEPTH);
    checks += 2;
    if (o_tx_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", o_tx_count); end
    if (o_tx_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", o_tx_full); end
    model_xfer(8);
    start(8);
    wait_done(300);
    tick();
    checks += 2;
    if (sent_q.size() != 8) begin errors++; $display("FAIL ovf_sent got %0d exp 8", sent_q.size()); end
    if (o_tx_count !== 4'd0) begin errors++; $display("FAIL ovf_drained got %0d exp 0", o_tx_count); end
    foreach (exp_sent[i]) if (i < sent_q.size()) begin
      checks++;
      if (sent_q[i] !== exp_sent[i]) begin errors++; $display("FAIL ovf_tx[%0d] got %h exp %h", i, sent_q[i], exp_sent[i]); end
    end
    for (int i = 0; i < 5; i++) begin
      pop(b); e = rx_exp.pop_front(); checks++;
      if (b !== e) begin errors++; $display("FAIL ovf_rx got %h exp %h", b, e); end
    end
    // Host pop lands on the same edge as the controller's RX push
    clr();
    lat_lo = 0; lat_hi = 0;
    x = 8'($urandom);
    wr(x, 1);
    model_xfer(1);
    start(1);
    while (!o_ctl_tx_dv && t < 20) begin @(negedge i_clk); t++; end
    @(posedge i_clk); #2;
    b = o_rd_data;
    i_rd_en = 1;
    @(posedge i_clk); #2;
    i_rd_en = 0;
    e = rx_exp.pop_front();
    checks += 2;
    if (o_rx_count !== 4'd3) begin errors++; $display("FAIL simul_count got %0d exp 3", o_rx_count); end
    if (b !== e) begin errors++; $display("FAIL simul_pop got %h exp %h", b, e); end
    wait_done(100);
    while (rx_exp.size() > 0) begin
      pop(b); e = rx_exp.pop_front(); checks++;
      if (b !== e) begin errors++; $display("FAIL simul_rx got %h exp %h", b, e); end
    end
    lat_hi = 2;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b, e;
    clr();
    lat_lo = 6; lat_hi = 6;
    for (int i = 0; i < 4; i++) wr(8'($urandom), 1);
    start(4);
    wait_sent(2, 100);
    i_reset_n = 0;
    #1;
    checks += 6;
    if (o_spi_cs_n !== 1'b1) begin errors++; $display("FAIL rmid_cs got %b exp 1", o_spi_cs_n); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", o_busy); end
    if (o_tx_count !== 4'd0) begin errors++; $display("FAIL rmid_tx_count got %0d exp 0", o_tx_count); end
    if (o_rx_count !== 4'd0) begin errors++; $display("FAIL rmid_rx_count got %0d exp 0", o_rx_count); end
    if (o_rx_empty !== 1'b1) begin errors++; $display("FAIL rmid_rx_empty got %b exp 1", o_rx_empty); end
    if (o_ctl_tx_dv !== 1'b0) begin errors++; $display("FAIL rmid_tx_dv got %b exp 0", o_ctl_tx_dv); end
    repeat (2) tick();
    i_reset_n = 1;
    tx_exp.delete(); rx_exp.delete();
    lat_lo = 0; lat_hi = 2;
    tick();
    clr();
    wr(8'($urandom), 1); wr(8'($urandom), 1);
    model_xfer(2);
    start(2);
    wait_done(100);
    tick();
    checks++;
    if (sent_q.size() != 2) begin errors++; $display("FAIL rmid_after_count got %0d exp 2", sent_q.size()); end
    foreach (exp_sent[i]) if (i < sent_q.size()) begin
      checks++;
      if (sent_q[i] !== exp_sent[i]) begin errors++; $display("FAIL rmid_tx[%0d] got %h exp %h", i, sent_q[i], exp_sent[i]); end
    end
    while (rx_exp.size() > 0) begin
      pop(b); e = rx_exp.pop_front(); checks++;
      if (b !== e) begin errors++; $display("FAIL rmid_rx got %h exp %h", b, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_random();
    test_backpressure();
    test_underflow();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
